// File: rtl/demux_pkg.sv
// Shared constants and helpers for the buffered 1:2 demultiplexer.
// Channel encodings match the 'select' input.
package demux_pkg;

  localparam logic CH1 = 1'b0;
  localparam logic CH2 = 1'b1;

  // Minimum bits needed to index 'value' distinct items (value >= 2).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO with occupancy counter; head reads as zero when empty.
// Push while full and pop while empty are ignored internally.
module demux_fifo
  import demux_pkg::*;
#(
  parameter int size  = 32,
  parameter int depth = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [size-1:0] din,
  output logic            full,
  output logic            empty,
  output logic [size-1:0] head
);

  localparam int ptr_w = clog2(depth);
  localparam int occ_w = clog2(depth + 1);

  logic [size-1:0]  mem_q [depth];
  logic [size-1:0]  mem_d [depth];
  logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [occ_w-1:0] occ_q, occ_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (occ_q == occ_w'(depth));
  assign empty     = (occ_q == {occ_w{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Next-state: write at wr_ptr, advance pointers; depth is a power of two so pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + ptr_w'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + ptr_w'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   occ_d = occ_q + occ_w'(1);
      2'b01:   occ_d = occ_q - occ_w'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State register with synchronous reset that discards all stored words.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= {size{1'b0}};
      end
      wr_ptr_q <= {ptr_w{1'b0}};
      rd_ptr_q <= {ptr_w{1'b0}};
      occ_q    <= {occ_w{1'b0}};
    end else begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Head word, forced to zero when nothing is stored.
  always_comb begin
    if (empty) begin
      head = {size{1'b0}};
    end else begin
      head = mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/demux_1to2_buffered.sv
// Routes one valid/ready stream into two independently buffered output channels,
// with per-channel delivered-word counters.
module demux_1to2_buffered
  import demux_pkg::*;
#(
  parameter int size  = 32,
  parameter int depth = 2,
  parameter int cnt_w = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             select,
  input  logic [size-1:0]  dato,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [size-1:0]  salida1,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [size-1:0]  salida2,
  output logic [cnt_w-1:0] count1,
  output logic [cnt_w-1:0] count2
);

  logic             full1_s, full2_s;
  logic             empty1_s, empty2_s;
  logic             sel_full_s;
  logic             push_s, push1_s, push2_s;
  logic             pop1_s, pop2_s;
  logic [cnt_w-1:0] count1_q, count1_d;
  logic [cnt_w-1:0] count2_q, count2_d;

  // Ready depends only on the selected FIFO, never on the consumers' ready.
  always_comb begin
    if (select == CH2) begin
      sel_full_s = full2_s;
    end else begin
      sel_full_s = full1_s;
    end
    in_ready = !sel_full_s && !rst;
  end

  assign push_s  = in_valid && in_ready;
  assign push1_s = push_s && (select == CH1);
  assign push2_s = push_s && (select == CH2);

  assign out1_valid = !empty1_s;
  assign out2_valid = !empty2_s;
  assign pop1_s     = out1_valid && out1_ready;
  assign pop2_s     = out2_valid && out2_ready;

  demux_fifo #(
    .size  (size),
    .depth (depth)
  ) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1_s),
    .pop   (pop1_s),
    .din   (dato),
    .full  (full1_s),
    .empty (empty1_s),
    .head  (salida1)
  );

  demux_fifo #(
    .size  (size),
    .depth (depth)
  ) u_fifo2 (
    .clk   (clk),
    .rst   (rst),
    .push  (push2_s),
    .pop   (pop2_s),
    .din   (dato),
    .full  (full2_s),
    .empty (empty2_s),
    .head  (salida2)
  );

  // Delivered-word counters wrap silently.
  always_comb begin
    count1_d = count1_q;
    count2_d = count2_q;
    if (pop1_s) begin
      count1_d = count1_q + cnt_w'(1);
    end else begin
      count1_d = count1_q;
    end
    if (pop2_s) begin
      count2_d = count2_q + cnt_w'(1);
    end else begin
      count2_d = count2_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count1_q <= {cnt_w{1'b0}};
      count2_q <= {cnt_w{1'b0}};
    end else begin
      count1_q <= count1_d;
      count2_q <= count2_d;
    end
  end

  assign count1 = count1_q;
  assign count2 = count2_q;

endmodule
